vx_tcu_tfr_accum: RTL

VX_TCU_TFR_ACCUM -- requirements
Module: VX_tcu_tfr_accum

---
 rtl/vx_tcu_tfr_accum.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vx_tcu_tfr_accum.sv
// Tensor-core FEDP tail stage: sums aligned partial terms over a multi-beat request and
// hands a sign-magnitude accumulator plus merged exception flags to the normaliser.
package vx_tcu_tfr_accum_pkg;
   typedef struct packed {
      logic is_nan;
      logic is_inf;
      logic sign;
   } fedp_excep_t;
endpackage

module vx_tcu_tfr_accum
   import vx_tcu_tfr_accum_pkg::*;
#(
   parameter string       INSTANCE_ID = "",
   parameter int unsigned WA          = 30,
   parameter int unsigned EXP_W       = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic              first_in,
   input  logic              last_in,
   input  logic [31:0]       req_id_in,
   input  logic [EXP_W-1:0]  max_exp_in,
   input  logic [WA-1:0]     term_in,
   input  logic              sticky_in,
   input  logic              is_int_in,
   input  fedp_excep_t       excep_in,
   output logic              valid_out,
   input  logic              ready_out,
   output logic [31:0]       req_id_out,
   output logic [EXP_W-1:0]  max_exp,
   output logic [WA-1:0]     acc_sig,
   output logic              sticky_out,
   output logic              is_int,
   output fedp_excep_t       exceptions
);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e            state_q, state_d;
   logic [WA-1:0]     acc_q, acc_d;
   logic              sticky_q, sticky_d;
   fedp_excep_t       exc_q, exc_d;
   logic [31:0]       req_id_q, req_id_d;
   logic [EXP_W-1:0]  max_exp_q, max_exp_d;
   logic              is_int_q, is_int_d;

   logic              in_fire, out_fire;
   logic              merged_nan, merged_inf, merged_sign;
   logic              is_min;
   logic [WA-1:0]     mag;
   logic              unused_mag_msb;
   logic              unused_instance_id;

   assign valid_out = (state_q == StDone);
   assign out_fire  = valid_out && ready_out;
   assign ready_in  = (state_q != StDone) || out_fire;
   assign in_fire   = valid_in && ready_in;

   // Opposite-signed infinities collapse to NaN; the sign tracks the first infinity seen.
   assign merged_nan  = exc_q.is_nan | excep_in.is_nan
                      | (exc_q.is_inf & excep_in.is_inf & (exc_q.sign ^ excep_in.sign));
   assign merged_inf  = (exc_q.is_inf | excep_in.is_inf) & ~merged_nan;
   assign merged_sign = exc_q.is_inf ? exc_q.sign : (excep_in.is_inf ? excep_in.sign : exc_q.sign);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sticky_d  = sticky_q;
      exc_d     = exc_q;
      req_id_d  = req_id_q;
      max_exp_d = max_exp_q;
      is_int_d  = is_int_q;
      if (out_fire) begin
         state_d = StIdle;
      end
      if (in_fire) begin
         if (first_in) begin
            acc_d     = term_in;
            sticky_d  = sticky_in;
            exc_d     = {excep_in.is_nan, excep_in.is_inf & ~excep_in.is_nan, excep_in.sign};
            req_id_d  = req_id_in;
            max_exp_d = max_exp_in;
            is_int_d  = is_int_in;
            state_d   = last_in ? StDone : StAccum;
         end else if (state_q == StAccum) begin
            acc_d    = acc_q + term_in;
            sticky_d = sticky_q | sticky_in;
            exc_d    = {merged_nan, merged_inf, merged_sign};
            if (last_in) begin
               state_d = StDone;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         sticky_q  <= 1'b0;
         exc_q     <= '0;
         req_id_q  <= '0;
         max_exp_q <= '0;
         is_int_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         sticky_q  <= sticky_d;
         exc_q     <= exc_d;
         req_id_q  <= req_id_d;
         max_exp_q <= max_exp_d;
         is_int_q  <= is_int_d;
      end
   end

   // The most negative value has no representable magnitude: saturate and flag inexact.
   assign is_min = (acc_q == {1'b1, {(WA-1){1'b0}}});
   assign mag    = acc_q[WA-1] ? (~acc_q + 1'b1) : acc_q;

   assign acc_sig    = {acc_q[WA-1], is_min ? {(WA-1){1'b1}} : mag[WA-2:0]};
   assign sticky_out = sticky_q | is_min;
   assign req_id_out = req_id_q;
   assign max_exp    = max_exp_q;
   assign is_int     = is_int_q;
   assign exceptions = exc_q;

   assign unused_mag_msb     = mag[WA-1];
   assign unused_instance_id = (INSTANCE_ID == "");

`ifdef DBG_TRACE_TCU
   always_ff @(posedge clk) begin
      if (!reset && out_fire) begin
         $display("%t: %s tfr-accum: req_id=0x%0h, acc_sig=0x%0h, nan=%b, inf=%b, sign=%b",
                  $time, INSTANCE_ID, req_id_q, acc_sig, exc_q.is_nan, exc_q.is_inf, exc_q.sign);
      end
   end
`endif

endmodule
